parity_bit_checker: RTL and testbench

PARITY_BIT_CHECKER -- requirements
Module: parity_bit_checker

---
 rtl/parity_pkg.sv | 11 +
 rtl/parity_err_counter.sv | 24 ++
 rtl/parity_bit_checker.sv | 48 ++++
 tb/tb_parity_bit_checker.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared constants and parity mode encoding for the parity checker
package parity_pkg;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parityMode_e;

endpackage

// File: rtl/parity_err_counter.sv
// rtl/parity_err_counter.sv - saturating error-cycle counter
module parity_err_counter
    import parity_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             incEn,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // An unknown incEn takes the hold branch, so X never reaches the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (incEn && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parity_bit_checker.sv
// rtl/parity_bit_checker.sv - 4-bit parity checker with registered flag, sticky flag and error counter
module parity_bit_checker
    import parity_pkg::*;
#(
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inA,
    input  logic             inB,
    input  logic             inC,
    input  logic             inD,
    input  logic             inP,
    output logic             outPEC,
    output logic             outPEC_r,
    output logic             outSTICKY,
    output logic [CNT_W-1:0] outERRCNT
);

    localparam parityMode_e MODE = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;
    localparam logic        MODE_INV = (MODE == PARITY_ODD);

    assign outPEC = inA ^ inB ^ inC ^ inD ^ inP ^ MODE_INV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outPEC_r  <= 1'b0;
            outSTICKY <= 1'b0;
        end else begin
            outPEC_r <= outPEC;
            if (outPEC) begin
                outSTICKY <= 1'b1;
            end
        end
    end

    // Counts cycles whose registered flag is set, so it trails outPEC_r by one edge.
    parity_err_counter #(
        .CNT_W (CNT_W)
    ) u_errCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .incEn (outPEC_r),
        .count (outERRCNT)
    );

endmodule

// File: tb/tb_parity_bit_checker.sv
// tb/tb_parity_bit_checker.sv - directed self-checking bench for parity_bit_checker
`timescale 1ns/1ps
module tb_parity_bit_checker;

    logic       clk;
    logic       rstN;
    logic       a, b, c, d, p;
    logic       pecE, pecRE, stickyE;
    logic [7:0] cntE;
    logic       pecO, pecRO, stickyO;
    logic [7:0] cntO;

    int checks = 0;
    int errors = 0;

    parity_bit_checker #(.ODD_PARITY(0), .CNT_W(8)) dutEven (
        .clk(clk), .rst_n(rstN), .inA(a), .inB(b), .inC(c), .inD(d), .inP(p),
        .outPEC(pecE), .outPEC_r(pecRE), .outSTICKY(stickyE), .outERRCNT(cntE)
    );

    parity_bit_checker #(.ODD_PARITY(1), .CNT_W(8)) dutOdd (
        .clk(clk), .rst_n(rstN), .inA(a), .inB(b), .inC(c), .inD(d), .inP(p),
        .outPEC(pecO), .outPEC_r(pecRO), .outSTICKY(stickyO), .outERRCNT(cntO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic setIn(input logic [4:0] v);
        {a, b, c, d, p} = v;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0;
        setIn(5'b00000);
        #1;
        check("rst_pec_r", pecRE, 0);
        check("rst_sticky", stickyE, 0);
        check("rst_cnt", cntE, 0);
        check("even_all0", pecE, 0);
        check("odd_all0", pecO, 1);

        // Clockless-style sweep held in reset: A/B/C/D/P toggle at 400/200/100/50/25 ns.
        for (int k = 0; k < 32; k++) begin
            logic [4:0] v;
            v = k[4:0];
            setIn(v);
            #1;
            check($sformatf("sweep_even_%0d", k), pecE, ($countones(v) % 2));
            check($sformatf("sweep_odd_%0d", k), pecO, 1 - ($countones(v) % 2));
            #24;
        end

        setIn(5'b10000);
        #1;
        check("even_A1", pecE, 1);
        check("odd_A1", pecO, 0);
        setIn(5'b10001);
        #1;
        check("even_A1P1", pecE, 0);
        setIn(5'b01100);
        #1;
        check("even_BC", pecE, 0);
        setIn(5'b01110);
        #1;
        check("even_BCD", pecE, 1);
        check("inrst_pec_r", pecRE, 0);
        check("inrst_sticky", stickyE, 0);
        check("inrst_cnt", cntE, 0);

        // Error held for three edges after reset release.
        setIn(5'b00000);
        @(negedge clk);
        rstN = 1'b1;
        setIn(5'b10000);
        #1;
        check("err_pec_r_before_edge", pecRE, 0);
        tick(1);
        check("err_pec_r_e1", pecRE, 1);
        check("err_sticky_e1", stickyE, 1);
        check("err_cnt_e1", cntE, 0);
        tick(2);
        check("err_cnt_e3", cntE, 2);
        setIn(5'b00000);
        tick(1);
        check("err_cnt_drain", cntE, 3);
        check("err_pec_r_clear", pecRE, 0);
        tick(1);
        check("err_cnt_hold", cntE, 3);
        check("err_sticky_hold", stickyE, 1);

        // Bring count to 5, then reset between edges.
        setIn(5'b00100);
        tick(2);
        setIn(5'b00000);
        tick(2);
        check("mid_cnt5", cntE, 5);
        #2;
        rstN = 1'b0;
        #1;
        check("async_pec_r", pecRE, 0);
        check("async_sticky", stickyE, 0);
        check("async_cnt", cntE, 0);
        tick(1);
        rstN = 1'b1;
        tick(3);
        check("post_rst_cnt", cntE, 0);
        check("post_rst_sticky", stickyE, 0);

        // Unknown data must not leave the counter corrupted once inputs are known.
        a = 1'bx;
        tick(2);
        setIn(5'b00000);
        tick(2);
        check("x_cnt", cntE, 0);
        check("x_pec_r", pecRE, 0);

        // Saturation under a long error.
        setIn(5'b00010);
        tick(2);
        check("resume_cnt1", cntE, 1);
        tick(253);
        check("sat_cnt254", cntE, 254);
        tick(1);
        check("sat_cnt255", cntE, 255);
        tick(1);
        check("sat_no_wrap", cntE, 255);
        tick(43);
        check("sat_300", cntE, 255);
        setIn(5'b00000);
        tick(1);
        check("sat_last_err", cntE, 255);
        tick(1);
        check("sat_idle", cntE, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
